store_buffer: RTL

- Store-side counterpart of the load data extractor, placed between the MEM stage and the data memory write port.
- Accepts store requests (funct3, byte address, rs2 data) and produces the write data and 4-bit byte write-enable for the addressed word lane.
- Queues stores in a small FIFO and drains them to memory over a req/ack handshake.
- Also flags misaligned stores, reports load-address hazards against queued stores, and supports a fence/drain request.

---
 rtl/store_buffer_pkg.sv | 26 ++
 rtl/store_buffer_align.sv | 44 ++++
 rtl/store_buffer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer.
//   state_t : drain FSM states (ST_IDLE, ST_REQ)
//   entry_t : one queued store {word address, lane data, byte enables}
//   FNC_*   : store funct3 encodings
package store_buffer_pkg;

    localparam int unsigned WADDR_W = 30;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned WE_W    = 4;

    localparam logic [2:0] FNC_SB = 3'b000;
    localparam logic [2:0] FNC_SH = 3'b001;
    localparam logic [2:0] FNC_SW = 3'b010;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    typedef struct packed {
        logic [WADDR_W-1:0] waddr;
        logic [DATA_W-1:0]  wdata;
        logic [WE_W-1:0]    we;
    } entry_t;

endpackage

// File: rtl/store_buffer_align.sv
// Store alignment: replicates rs2 data into the addressed lane(s) and builds
// the byte enables.
//   i_funct3   : store size (FNC_SB/FNC_SH/FNC_SW)
//   i_off      : byte offset, st_addr[1:0]
//   i_data     : raw rs2 value
//   o_wdata    : lane-replicated write data
//   o_we       : byte write enables
//   o_misalign : request must not be enqueued (misaligned or illegal funct3)
module store_buffer_align
    import store_buffer_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_data,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_we,
    output logic        o_misalign
);

    always_comb begin
        o_wdata    = '0;
        o_we       = '0;
        o_misalign = 1'b0;
        case (i_funct3)
            FNC_SB: begin
                o_wdata = {4{i_data[7:0]}};
                o_we    = 4'b0001 << i_off;
            end
            FNC_SH: begin
                o_wdata    = {2{i_data[15:0]}};
                o_we       = i_off[1] ? 4'b1100 : 4'b0011;
                o_misalign = i_off[0];
            end
            FNC_SW: begin
                o_wdata    = i_data;
                o_we       = 4'b1111;
                o_misalign = (i_off != 2'b00);
            end
            // Illegal sizes are reported through the same flag.
            default: o_misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and the data memory write port.
//   clk, rst_n            : clock, async active-low reset
//   st_valid/st_ready     : store request handshake (st_ready = !full)
//   st_funct3/addr/data   : store size, byte address, raw rs2 value
//   st_err                : pulse the cycle after a rejected (bad) store
//   mem_req/addr/wdata/we : head write request, held until mem_ack
//   mem_ack               : memory accepted the head write
//   ld_addr/ld_hit        : load address hazard against queued stores
//   fence_req/fence_done  : drain request / buffer empty while requested
//   count                 : occupancy
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             st_valid,
    output logic             st_ready,
    input  logic [2:0]       st_funct3,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    output logic             st_err,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_we,
    input  logic             mem_ack,
    input  logic [31:0]      ld_addr,
    output logic             ld_hit,
    input  logic             fence_req,
    output logic             fence_done,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    entry_t             r_mem [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic               r_err;
    state_t             r_state;
    state_t             w_state_nxt;

    logic [31:0]        w_wdata;
    logic [3:0]         w_we;
    logic               w_bad;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic [CNT_W-1:0]   w_count_nxt;
    logic               w_hit;
    entry_t             w_head;
    logic               w_unused_ld;

    store_buffer_align u_align (
        .i_funct3   (st_funct3),
        .i_off      (st_addr[1:0]),
        .i_data     (st_data),
        .o_wdata    (w_wdata),
        .o_we       (w_we),
        .o_misalign (w_bad)
    );

    assign st_ready    = (r_count != CNT_W'(DEPTH));
    assign w_accept    = st_valid && st_ready;
    assign w_push      = w_accept && !w_bad;
    assign w_pop       = (r_state == ST_REQ) && mem_ack;
    assign w_head      = r_mem[r_head];
    assign w_unused_ld = ^ld_addr[1:0];

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)
            w_count_nxt = r_count + CNT_W'(1);
        else if (w_pop && !w_push)
            w_count_nxt = r_count - CNT_W'(1);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (r_count != '0) w_state_nxt = ST_REQ;
            ST_REQ:  if (w_pop && (w_count_nxt == '0)) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Head fields are gated so the write port reads all-zero while idle.
    always_comb begin
        mem_req   = (r_state == ST_REQ);
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = '0;
        if (mem_req) begin
            mem_addr  = {w_head.waddr, 2'b00};
            mem_wdata = w_head.wdata;
            mem_we    = w_head.we;
        end
    end

    always_comb begin
        w_hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_mem[i].waddr == ld_addr[31:2]))
                w_hit = 1'b1;
        end
    end

    assign ld_hit     = w_hit;
    assign st_err     = r_err;
    assign count      = r_count;
    assign fence_done = fence_req && (r_count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Push and pop never touch the same slot: a pop needs count>0 and a
    // push needs count<DEPTH, so head==tail cannot hold for both at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err   <= w_accept && w_bad;
            r_count <= w_count_nxt;
            if (w_push) begin
                r_mem[r_tail]   <= '{waddr: st_addr[31:2], wdata: w_wdata, we: w_we};
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_W'(1);
            end
        end
    end

endmodule
